// File: rtl/video_in_pkg.sv
// Shared types and sizing for the video-input capture path (FIFO -> Wishbone writer).
package video_in_pkg;

    localparam int DATA_SIZE   = 32;
    localparam int NB_PACK     = 16;
    localparam int ADR_W       = 32;
    localparam int FRAME_WORDS = 76800;

    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_EOB  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_pack_writer_frame_addr_gen.sv
// Frame-buffer address generator: word index within the frame, latched frame base,
// wrap at frame end and the frame_done pulse.
module frame_addr_gen #(
    parameter int ADR_W       = video_in_pkg::ADR_W,
    parameter int FRAME_WORDS = video_in_pkg::FRAME_WORDS
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             i_start,
    input  logic             i_advance,
    input  logic [ADR_W-1:0] i_frame_base,
    output logic [ADR_W-1:0] o_addr,
    output logic             o_frame_done
);

    localparam int IDX_W = $clog2(FRAME_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

    logic [IDX_W-1:0] r_word_idx;
    logic [ADR_W-1:0] r_cur_base;
    logic             r_frame_done;
    logic             w_last_word;

    assign w_last_word = (r_word_idx == LAST_IDX);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_word_idx   <= '0;
            r_cur_base   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            // Base is only re-sampled at a frame boundary so a frame is never split
            if (i_start && (r_word_idx == '0)) begin
                r_cur_base <= i_frame_base;
            end
            if (i_advance) begin
                r_word_idx <= w_last_word ? '0 : r_word_idx + 1'b1;
            end
            r_frame_done <= i_advance && w_last_word;
        end
    end

    assign o_addr       = r_cur_base + (ADR_W'(r_word_idx) << 2);
    assign o_frame_done = r_frame_done;

endmodule

// File: rtl/wb_pack_writer.sv
// Drains one NB_PACK-word pack from the video FIFO per Wishbone incrementing burst.
// IDLE waits for a pack, LOAD pops/captures one word (stb low), WRITE holds the beat until ack.
module wb_pack_writer
    import video_in_pkg::*;
#(
    parameter int DATA_SIZE   = video_in_pkg::DATA_SIZE,
    parameter int NB_PACK     = video_in_pkg::NB_PACK,
    parameter int ADR_W       = video_in_pkg::ADR_W,
    parameter int FRAME_WORDS = video_in_pkg::FRAME_WORDS
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 i_enable,
    input  logic [ADR_W-1:0]     i_frame_base,
    input  logic [DATA_SIZE-1:0] i_fifo_data,
    input  logic                 i_fifo_pack_avail,
    output logic                 o_fifo_r_ack,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    output logic                 o_wb_we,
    output logic [ADR_W-1:0]     o_wb_adr,
    output logic [DATA_SIZE-1:0] o_wb_dat,
    output logic [3:0]           o_wb_sel,
    output logic [2:0]           o_wb_cti,
    output logic [1:0]           o_wb_bte,
    input  logic                 i_wb_ack,
    output logic                 o_frame_done
);

    localparam int BEAT_W = $clog2(NB_PACK);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NB_PACK - 1);

    wb_state_t            r_state;
    logic [BEAT_W-1:0]    r_beat_cnt;
    logic                 r_cyc;
    logic                 r_stb;
    logic                 r_r_ack;
    logic [DATA_SIZE-1:0] r_dat;
    logic [ADR_W-1:0]     r_adr;
    logic [2:0]           r_cti;

    logic                 w_start;
    logic                 w_advance;
    logic [ADR_W-1:0]     w_addr;

    assign w_start   = (r_state == IDLE) && i_enable && i_fifo_pack_avail;
    assign w_advance = (r_state == WRITE) && i_wb_ack;

    frame_addr_gen #(
        .ADR_W       (ADR_W),
        .FRAME_WORDS (FRAME_WORDS)
    ) u_addr (
        .clk          (clk),
        .nRST         (nRST),
        .i_start      (w_start),
        .i_advance    (w_advance),
        .i_frame_base (i_frame_base),
        .o_addr       (w_addr),
        .o_frame_done (o_frame_done)
    );

    // The pop in LOAD and the capture of the head word share one edge; the next LOAD is
    // at least two edges later, which is exactly the FIFO's read-after-pop latency.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_r_ack    <= 1'b0;
            r_dat      <= '0;
            r_adr      <= '0;
            r_cti      <= 3'b000;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cyc   <= 1'b0;
                    r_stb   <= 1'b0;
                    r_r_ack <= 1'b0;
                    if (w_start) begin
                        r_state    <= LOAD;
                        r_beat_cnt <= '0;
                        r_cyc      <= 1'b1;
                        r_r_ack    <= 1'b1;
                    end
                end
                LOAD: begin
                    r_r_ack <= 1'b0;
                    r_dat   <= i_fifo_data;
                    r_adr   <= w_addr;
                    r_cti   <= (r_beat_cnt == LAST_BEAT) ? CTI_EOB : CTI_INCR;
                    r_stb   <= 1'b1;
                    r_state <= WRITE;
                end
                WRITE: begin
                    if (i_wb_ack) begin
                        r_stb      <= 1'b0;
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (r_beat_cnt == LAST_BEAT) begin
                            r_state <= IDLE;
                            r_cyc   <= 1'b0;
                        end else begin
                            r_state <= LOAD;
                            r_r_ack <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cyc   <= 1'b0;
                    r_stb   <= 1'b0;
                    r_r_ack <= 1'b0;
                end
            endcase
        end
    end

    assign o_fifo_r_ack = r_r_ack;
    assign o_wb_cyc     = r_cyc;
    assign o_wb_stb     = r_stb;
    assign o_wb_we      = r_cyc;
    assign o_wb_adr     = r_adr;
    assign o_wb_dat     = r_dat;
    assign o_wb_sel     = {4{r_cyc}};
    assign o_wb_cti     = r_cti;
    assign o_wb_bte     = 2'b00;

endmodule

// File: tb/tb_wb_pack_writer.sv
// Scoreboard bench for wb_pack_writer: FIFO model plus a Wishbone slave with variable ack delay.
`timescale 1ns/1ps
module tb_wb_pack_writer;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NP = 16;
    localparam int FW = 32;

    logic           clk = 1'b0;
    logic           nRST = 1'b0;
    logic           i_enable = 1'b0;
    logic [AW-1:0]  i_frame_base = '0;
    logic [DW-1:0]  i_fifo_data;
    logic           i_fifo_pack_avail;
    logic           o_fifo_r_ack;
    logic           o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0]  o_wb_adr;
    logic [DW-1:0]  o_wb_dat;
    logic [3:0]     o_wb_sel;
    logic [2:0]     o_wb_cti;
    logic [1:0]     o_wb_bte;
    logic           i_wb_ack = 1'b0;
    logic           o_frame_done;

    always #5 clk = ~clk;

    wb_pack_writer #(
        .DATA_SIZE(DW), .NB_PACK(NP), .ADR_W(AW), .FRAME_WORDS(FW)
    ) dut (
        .clk(clk), .nRST(nRST), .i_enable(i_enable), .i_frame_base(i_frame_base),
        .i_fifo_data(i_fifo_data), .i_fifo_pack_avail(i_fifo_pack_avail),
        .o_fifo_r_ack(o_fifo_r_ack), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
        .o_wb_we(o_wb_we), .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
        .o_wb_cti(o_wb_cti), .o_wb_bte(o_wb_bte), .i_wb_ack(i_wb_ack),
        .o_frame_done(o_frame_done)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO model: pointer moves on the pop edge, registered RAM output shows the new head one edge later
    logic [31:0] mem [0:1023];
    int unsigned wr = 0;
    int unsigned rd;
    always @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            rd          <= 0;
            i_fifo_data <= '0;
        end else begin
            i_fifo_data <= mem[rd % 1024];
            rd          <= rd + (o_fifo_r_ack ? 1 : 0);
        end
    end
    assign i_fifo_pack_avail = ((wr - rd) >= NP);

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [2:0]  cti;
        bit          fend;
    } exp_t;
    exp_t exp_q[$];

    int unsigned n_words = 0;
    logic [31:0] m_base = '0;
    int words_pushed = 0;

    // Reference: n-th word since reset lands at frame base + 4*(n mod FW); base sampled at frame start
    task automatic push_word(input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        mem[wr % 1024] = d;
        wr++;
        words_pushed++;
        if (n_words % FW == 0) m_base = i_frame_base;
        e.adr  = m_base + 32'(4 * (n_words % FW));
        e.dat  = d;
        e.cti  = (n_words % NP == NP - 1) ? 3'b111 : 3'b010;
        e.fend = (n_words % FW == FW - 1);
        exp_q.push_back(e);
        n_words++;
    endtask

    task automatic push_pack_seq(input logic [31:0] first);
        for (int i = 0; i < NP; i++) push_word(first + 32'(i));
    endtask

    task automatic push_rand(input int cnt);
        for (int i = 0; i < cnt; i++) push_word($urandom);
    endtask

    // Wishbone slave + monitor
    int delay_mode = 0;
    int ack_wait = 0;
    int cur_delay = 0;
    int burst_pos = 0;
    bit fd_exp = 0;
    int cyc_cycles = 0;
    int pops = 0;
    logic [31:0] h_adr, h_dat;
    logic [2:0]  h_cti;

    always @(negedge clk) begin
        exp_t e;
        if (!nRST) begin
            i_wb_ack  = 1'b0;
            fd_exp    = 0;
            ack_wait  = 0;
            burst_pos = 0;
        end else begin
            chk("frame_done", o_frame_done, fd_exp);
            fd_exp = 0;
            if (o_wb_cyc) begin
                cyc_cycles++;
                chk("we_sel_bte", {o_wb_we, o_wb_sel, o_wb_bte}, {1'b1, 4'hF, 2'b00});
            end
            if (o_fifo_r_ack) pops++;
            if (burst_pos != 0) chk("cyc_held", o_wb_cyc, 1'b1);
            if (i_wb_ack) begin
                i_wb_ack = 1'b0;
                ack_wait = 0;
            end else if (o_wb_stb) begin
                if (ack_wait == 0) begin
                    h_adr = o_wb_adr;
                    h_dat = o_wb_dat;
                    h_cti = o_wb_cti;
                    cur_delay = (delay_mode > 3) ? int'($urandom_range(0, 3)) : delay_mode;
                end else begin
                    chk("hold", {o_wb_adr, o_wb_dat, o_wb_cti}, {h_adr, h_dat, h_cti});
                end
                if (ack_wait >= cur_delay) begin
                    i_wb_ack = 1'b1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat: got adr %0h expected none", o_wb_adr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("adr", o_wb_adr, e.adr);
                        chk("dat", o_wb_dat, e.dat);
                        chk("cti", o_wb_cti, e.cti);
                        fd_exp = e.fend;
                    end
                    burst_pos = (burst_pos + 1) % NP;
                end else begin
                    ack_wait++;
                end
            end
        end
    end

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || o_wb_cyc) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", t < 3000, 1'b1);
        repeat (3) @(negedge clk);
        chk("fifo_empty", wr - rd, 0);
        chk("pops", pops, words_pushed);
    endtask

    task automatic wait_burst_pos(input int p);
        int t = 0;
        while (!(burst_pos == p && o_wb_stb) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("burst_pos_timeout", t < 500, 1'b1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        chk("rst_cyc_stb_ack", {o_wb_cyc, o_wb_stb, o_fifo_r_ack, o_wb_we}, 4'b0);
        chk("rst_adr", o_wb_adr, 0);
        chk("rst_dat", o_wb_dat, 0);
        chk("rst_cti_sel_bte", {o_wb_cti, o_wb_sel, o_wb_bte}, 9'b0);
        chk("rst_frame_done", o_frame_done, 0);
        @(negedge clk);
        nRST = 1'b1;
        i_enable = 1'b1;

        // Single burst, zero-wait ack
        i_frame_base = 32'h4000;
        delay_mode = 0;
        cyc_cycles = 0;
        push_pack_seq(32'h100);
        wait_drain();
        chk("cyc_cycles_d0", cyc_cycles, 2 * NP);

        // Three-cycle ack delay, completes the first frame
        delay_mode = 3;
        cyc_cycles = 0;
        push_pack_seq(32'h100);
        wait_drain();
        chk("cyc_cycles_d3", cyc_cycles, 5 * NP);

        // New frame at base 0, base change mid-frame only applies at the following frame
        delay_mode = 4;
        i_frame_base = 32'h0;
        push_pack_seq(32'h200);
        wait_drain();
        i_frame_base = 32'h800;
        push_pack_seq(32'h300);
        wait_drain();
        push_pack_seq(32'h400);
        wait_drain();

        // Disabled with packs waiting, then enable dropped mid-burst
        i_enable = 1'b0;
        cyc_cycles = 0;
        push_rand(2 * NP);
        repeat (20) @(negedge clk);
        chk("disabled_no_cyc", cyc_cycles, 0);
        chk("disabled_no_pop", wr - rd, 2 * NP);
        i_enable = 1'b1;
        wait_burst_pos(5);
        i_enable = 1'b0;
        t = 0;
        while (o_wb_cyc && t < 500) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        chk("en_drop_cyc", o_wb_cyc, 0);
        chk("en_drop_fifo_left", wr - rd, NP);
        chk("en_drop_exp_left", exp_q.size(), NP);
        i_enable = 1'b1;
        wait_drain();

        // 15 words: nothing; 16th word starts the burst promptly
        cyc_cycles = 0;
        push_rand(NP - 1);
        repeat (20) @(negedge clk);
        chk("partial_no_cyc", cyc_cycles, 0);
        push_rand(1);
        t = 0;
        while (!o_wb_cyc && t < 5) begin
            @(negedge clk);
            t++;
        end
        chk("start_latency", t <= 2, 1'b1);
        wait_drain();

        // Randomised packs, delays and bases
        for (int it = 0; it < 6; it++) begin
            delay_mode = 4;
            if ($urandom_range(0, 1) == 1) i_frame_base = {$urandom_range(0, 255), 12'h000};
            push_rand(NP * int'($urandom_range(1, 3)));
            wait_drain();
        end

        // Asynchronous reset during beat 7
        delay_mode = 1;
        push_rand(NP);
        wait_burst_pos(7);
        #2;
        nRST = 1'b0;
        #1;
        chk("async_rst_outputs", {o_wb_cyc, o_wb_stb, o_fifo_r_ack}, 3'b000);
        chk("async_rst_adr", o_wb_adr, 0);
        exp_q.delete();
        wr = 0;
        n_words = 0;
        pops = 0;
        words_pushed = 0;
        i_frame_base = 32'h9000;
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        repeat (2) @(negedge clk);
        push_rand(NP);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
